acc_driver: RTL
===============

# acc_driver

Job-level initiator for the accumulator core's streaming input port. It accepts a job (length, base value, step) from a controller and emits the number stream with `valid`/`run` framing. It then waits for the core's `valid`/`result` response and reports the result, together with an internally computed expected sum and a mismatch flag. It sits between the system controller and the accumulator core, and doubles as a self-checking stimulus engine in bring-up.

## Interface
Parameters:
- `IN_DATA_WIDTH`, 8: width of each streamed number.
- `DWIDTH`, 16: width of the accumulated result.
- `CNT_WIDTH`, 8: width of the job length field.
- `TIMEOUT`, 16: maximum cycles spent in WAIT before aborting; must be ≥1.

Ports:
- `clk` input, 1: single clock; all logic rises on posedge.
- `reset` input, 1: synchronous, active-high.
- `start_i` input, 1: job request; sampled only in IDLE.
- `len_i` input, CNT_WIDTH: number of beats; sampled with `start_i`.
- `base_i` input, IN_DATA_WIDTH: first number; sampled with `start_i`.
- `step_i` input, IN_DATA_WIDTH: increment per beat; sampled with `start_i`.
- `busy_o` output, 1: high from the cycle after an accepted start through DONE.
- `done_o` output, 1: one-cycle completion pulse.
- `result_o` output, DWIDTH: captured core result; held until the next accepted start.
- `expected_o` output, DWIDTH: locally computed sum; held like `result_o`.
- `mismatch_o` output, 1: `result_o != expected_o`; valid while `done_o` is high and held afterwards.
- `timeout_o` output, 1: job aborted by timeout; held like `mismatch_o`.
- `number_o` output, IN_DATA_WIDTH: stream data to the core.
- `valid_o` output, 1: stream beat qualifier to the core.
- `run_o` output, 1: job framing to the core.
- `acc_valid_i` input, 1: core result valid.
- `acc_result_i` input, DWIDTH: core result.

## Operation
- The FSM has four states: IDLE, RUN, WAIT, DONE.
- **IDLE**
  - `start_i`=1 with `len_i`>0: latch the job, clear `expected_o`/`mismatch_o`/`timeout_o`, go to RUN.
  - `start_i`=1 with `len_i`=0: go directly to DONE. No beats are emitted, `run_o` stays 0, `result_o`=`expected_o`=0, `mismatch_o`=0.
- **RUN**
  - `valid_o`=`run_o`=1 each cycle.
  - `number_o` = base + k·step mod 2^IN_DATA_WIDTH, for k = 0..len-1.
  - `expected_o` += zero-extended `number_o`, mod 2^DWIDTH.
  - After beat len-1, go to WAIT.
  - `acc_valid_i` is ignored in RUN.
- **WAIT**
  - `valid_o`=0, `run_o`=1, `number_o`=0.
  - The first `acc_valid_i`=1 captures `acc_result_i` into `result_o` and moves to DONE.
  - After TIMEOUT cycles in WAIT with no `acc_valid_i`, set `timeout_o`=1, set `result_o`=0, and move to DONE.
- **DONE**
  - `done_o`=1 and `run_o`=0 for one cycle.
  - `mismatch_o` = (`result_o` != `expected_o`) OR `timeout_o`.
  - Return to IDLE.
- `start_i` outside IDLE is ignored (no queueing).
- Reset at any time:
  - next edge: IDLE;
  - all outputs 0, including held result/expected/flags;
  - beat and timeout counters cleared.

## Timing
- Reset values: every output is 0.
- Start accepted at edge E0:
  - beat k is presented in the cycle after edge E0+k (k = 0..len-1);
  - WAIT begins at edge E0+len.
- Core response:
  - If `acc_valid_i` is sampled at edge Ew, `done_o` is high during the cycle after Ew.
  - `result_o` updates at Ew.
- Minimum job turnaround is len+2 cycles from start to `done_o`, with a core that responds in its first WAIT cycle.
- Back-to-back jobs: a new start is accepted in the first IDLE cycle after DONE, i.e. a 1-cycle gap.
- `busy_o` = (state != IDLE), registered.

## Structure
- Shared package `acc_pkg` holds:
  - the state enum (IDLE/RUN/WAIT/DONE);
  - default width constants shared with the accumulator core (IN_DATA_WIDTH, DWIDTH).
- One sub-module, `acc_beat_gen`, handles beat generation:
  - holds the beat counter and the running number register (base + k·step);
  - inputs: load/advance;
  - outputs: `number` and `last`.
- The FSM, reference sum, capture and timeout logic live in `acc_driver`.

## Test plan
- **Basic sum:** len=100, base=1, step=0; bench core model returns the sum 1 cycle after the last beat.
  - Expect exactly 100 beats of 1 with `run_o` high throughout.
  - Expect `result_o`=`expected_o`=100, `mismatch_o`=0, `done_o` a single pulse.
- **Wrap:** len=3, base=255, step=1.
  - Expect `number_o` 255, 0, 1 and `expected_o`=256.
  - Faulty model returns 255 → `mismatch_o`=1.
- **Timeout:** model never asserts `acc_valid_i`, TIMEOUT=16.
  - Expect `done_o` 16 cycles into WAIT.
  - Expect `timeout_o`=1, `mismatch_o`=1, `result_o`=0.
- **Zero length:** len=0.
  - Expect no `valid_o`/`run_o` activity.
  - Expect `done_o` the cycle after start, with all results 0.
- **Busy start:** `start_i` pulsed mid-RUN with different fields.
  - Expect the current job unaffected and no second job started.
- **Reset mid-run:** `reset` asserted at beat 5 of 10.
  - Expect all outputs 0 at the next edge and state IDLE.
  - A fresh start then behaves as in the basic-sum scenario.

Source files
------------

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and default widths for the accumulator driver
package acc_pkg;

  // Default widths shared with the accumulator core
  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_DWIDTH        = 16;
  localparam int DEF_CNT_WIDTH     = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/acc_driver_beat_gen.sv
// rtl/acc_driver_beat_gen.sv - beat counter and arithmetic-progression number register
module acc_beat_gen
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     advance,
  input  logic [CNT_WIDTH-1:0]     len,
  input  logic [IN_DATA_WIDTH-1:0] base,
  input  logic [IN_DATA_WIDTH-1:0] step,
  output logic [IN_DATA_WIDTH-1:0] number,
  output logic                     last
);

  logic [IN_DATA_WIDTH-1:0] r_number;
  logic [IN_DATA_WIDTH-1:0] r_step;
  logic [CNT_WIDTH-1:0]     r_len;
  logic [CNT_WIDTH-1:0]     r_cnt;

  // Load the job on start, then step the number and beat index once per beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_number <= '0;
      r_step   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_number <= base;
      r_step   <= step;
      r_len    <= len;
      r_cnt    <= '0;
    end else if (advance) begin
      r_number <= r_number + r_step;
      r_cnt    <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign number = r_number;
  // len is never 0 once loaded, so len-1 cannot underflow in use
  assign last   = (r_cnt == r_len - CNT_WIDTH'(1));

endmodule

// File: rtl/acc_driver.sv
// rtl/acc_driver.sv - job-level stream initiator with reference sum, capture and timeout
module acc_driver
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     len_i,
  input  logic [IN_DATA_WIDTH-1:0] base_i,
  input  logic [IN_DATA_WIDTH-1:0] step_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic [DWIDTH-1:0]        expected_o,
  output logic                     mismatch_o,
  output logic                     timeout_o,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  output logic                     valid_o,
  output logic                     run_o,
  input  logic                     acc_valid_i,
  input  logic [DWIDTH-1:0]        acc_result_i
);

  localparam int             TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT - 1);

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_valid;
  logic                     r_run;
  logic                     r_mismatch;
  logic                     r_timeout;
  logic [DWIDTH-1:0]        r_result;
  logic [DWIDTH-1:0]        r_expected;
  logic [TW-1:0]            r_wait_cnt;

  logic                     w_load;
  logic                     w_advance;
  logic [IN_DATA_WIDTH-1:0] w_number;
  logic                     w_last;

  assign w_load    = (r_state == S_IDLE) && start_i && (len_i != '0);
  assign w_advance = (r_state == S_RUN);

  acc_beat_gen #(
    .IN_DATA_WIDTH (IN_DATA_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_beat_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .advance (w_advance),
    .len     (len_i),
    .base    (base_i),
    .step    (step_i),
    .number  (w_number),
    .last    (w_last)
  );

  // Job FSM: framing, reference sum, result capture, timeout and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_run      <= 1'b0;
      r_mismatch <= 1'b0;
      r_timeout  <= 1'b0;
      r_result   <= '0;
      r_expected <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_result   <= '0;
            r_expected <= '0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b1;
            if (len_i != '0) begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
              r_run   <= 1'b1;
            end else begin
              // Empty job completes without touching the core
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_expected <= r_expected + DWIDTH'(w_number);
          if (w_last) begin
            r_state    <= S_WAIT;
            r_valid    <= 1'b0;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (acc_valid_i) begin
            r_result   <= acc_result_i;
            r_mismatch <= (acc_result_i != r_expected);
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_run      <= 1'b0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_result   <= '0;
            r_timeout  <= 1'b1;
            r_mismatch <= 1'b1;
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_run      <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign valid_o    = r_valid;
  assign run_o      = r_run;
  assign result_o   = r_result;
  assign expected_o = r_expected;
  assign mismatch_o = r_mismatch;
  assign timeout_o  = r_timeout;
  // Number bus is forced to zero whenever no beat is being presented
  assign number_o   = r_valid ? w_number : '0;

endmodule
